// File: rtl/usb_phy_tx.sv
// usb_phy_tx: bit-level USB transmitter (LS/FS/HS).
// Takes packet bytes over a valid/ready handshake. Sends SYNC, then the
// bytes NRZI-encoded LSB first with bit stuffing, then an EOP of SE0 and
// J slots. One bit slot advances per clk cycle with bit_en high.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   bit_en            bit-slot strobe
//   tx_data/valid/last  byte stream in; tx_ready is combinational
//   line_state        registered bus state (SE0=00, J=01, K=10)
//   tx_oe, busy       registered output enable and packet-in-progress flag
//   underrun          one-clk pulse when a byte was missing mid-packet
//
// The state register describes the slot currently on the line. Each
// bit_en edge ends that slot and computes the next one.
module usb_phy_tx #(
    parameter int SYNC_LEN     = 8,
    parameter int STUFF_BITS_N = 6,
    parameter int EOP_SE0_N    = 2,
    parameter int EOP_J_N      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [1:0] line_state,
    output logic       tx_oe,
    output logic       busy,
    output logic       underrun
);
    localparam logic [1:0] LS_SE0    = 2'b00;
    localparam logic [1:0] LS_J      = 2'b01;
    localparam logic [1:0] LS_K      = 2'b10;
    localparam logic [4:0] SYNC_LAST = 5'(SYNC_LEN - 1);
    localparam logic [4:0] SE0_LAST  = 5'(EOP_SE0_N - 1);
    localparam logic [4:0] J_LAST    = 5'(EOP_J_N - 1);
    localparam logic [3:0] STUFF_N   = 4'(STUFF_BITS_N);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_DATA, S_STUFF, S_EOP_SE0, S_EOP_J
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] line_q, line_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       underrun_q, underrun_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] nbits_q, nbits_d;   // data bits still waiting in the shifter
    logic       last_q, last_d;     // final byte already accepted

    logic       load_slot;
    logic [1:0] line_tog;
    logic [7:0] sh_v;
    logic [3:0] nb_v;

    // A byte is taken while the last SYNC bit or the last bit of a
    // non-final byte is on the line.
    assign load_slot = (state_q == S_SYNC && cnt_q == SYNC_LAST) ||
                       (state_q == S_DATA && nbits_q == 4'd0 && !last_q);
    assign tx_ready  = bit_en && load_slot && !rst;
    assign line_tog  = (line_q == LS_K) ? LS_J : LS_K;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            line_q     <= LS_J;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            ones_q     <= 4'd0;
            shift_q    <= 8'd0;
            nbits_q    <= 4'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            ones_q     <= ones_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        underrun_d = 1'b0;
        ones_d     = ones_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        last_d     = last_q;
        sh_v       = shift_q;
        nb_v       = nbits_q;

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (tx_valid) begin
                        state_d = S_SYNC;
                        cnt_d   = 5'd0;
                        line_d  = line_tog;
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        ones_d  = 4'd0;
                        nbits_d = 4'd0;
                        last_d  = 1'b0;
                    end
                end
                S_SYNC, S_DATA, S_STUFF: begin
                    if (state_q == S_SYNC && cnt_q != SYNC_LAST) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q + 5'd1 == SYNC_LAST) begin
                            // closing SYNC one starts the ones count
                            ones_d = 4'd1;
                        end else begin
                            line_d = line_tog;
                        end
                    end else if (load_slot && !tx_valid) begin
                        // underrun ends the packet without a pending stuff bit
                        underrun_d = 1'b1;
                        state_d    = S_EOP_SE0;
                        cnt_d      = 5'd0;
                        line_d     = LS_SE0;
                    end else begin
                        if (load_slot) begin
                            sh_v   = tx_data;
                            nb_v   = 4'd8;
                            last_d = tx_last;
                        end
                        shift_d = sh_v;
                        nbits_d = nb_v;
                        if (ones_q == STUFF_N) begin
                            state_d = S_STUFF;
                            line_d  = line_tog;
                            ones_d  = 4'd0;
                        end else if (nb_v == 4'd0) begin
                            state_d = S_EOP_SE0;
                            cnt_d   = 5'd0;
                            line_d  = LS_SE0;
                        end else begin
                            state_d = S_DATA;
                            shift_d = sh_v >> 1;
                            nbits_d = nb_v - 4'd1;
                            if (sh_v[0]) begin
                                ones_d = ones_q + 4'd1;
                            end else begin
                                line_d = line_tog;
                                ones_d = 4'd0;
                            end
                        end
                    end
                end
                S_EOP_SE0: begin
                    if (cnt_q == SE0_LAST) begin
                        state_d = S_EOP_J;
                        cnt_d   = 5'd0;
                        line_d  = LS_J;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_EOP_J: begin
                    if (cnt_q == J_LAST) begin
                        state_d = S_IDLE;
                        oe_d    = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign line_state = line_q;
    assign tx_oe      = oe_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_usb_phy_tx.sv
module tb_usb_phy_tx;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       be1, v1, l1, rdy1, oe1, busy1, ur1;
    logic [7:0] d1;
    logic [1:0] ls1;
    logic       be2, v2, l2, rdy2, oe2, busy2, ur2;
    logic [7:0] d2;
    logic [1:0] ls2;

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nb;
        int         period;
        bit         under;
        int         exp_slots;
        int         exp_rdy;
        int         exp_ur;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    usb_phy_tx dut_a (
        .clk(clk), .rst(rst), .bit_en(be1), .tx_data(d1), .tx_valid(v1),
        .tx_last(l1), .tx_ready(rdy1), .line_state(ls1), .tx_oe(oe1),
        .busy(busy1), .underrun(ur1)
    );

    usb_phy_tx #(.SYNC_LEN(32), .STUFF_BITS_N(6), .EOP_SE0_N(1), .EOP_J_N(1)) dut_b (
        .clk(clk), .rst(rst), .bit_en(be2), .tx_data(d2), .tx_valid(v2),
        .tx_last(l2), .tx_ready(rdy2), .line_state(ls2), .tx_oe(oe2),
        .busy(busy2), .underrun(ur2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive(input bit sel, input logic be, input logic v,
                         input logic [7:0] d, input logic l);
        if (sel) begin
            be2 = be; v2 = v; d2 = d; l2 = l;
        end else begin
            be1 = be; v1 = v; d1 = d; l1 = l;
        end
    endtask

    function automatic logic [1:0] get_ls(input bit sel);
        return sel ? ls2 : ls1;
    endfunction
    function automatic logic get_oe(input bit sel);
        return sel ? oe2 : oe1;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy2 : busy1;
    endfunction
    function automatic logic get_rdy(input bit sel);
        return sel ? rdy2 : rdy1;
    endfunction
    function automatic logic get_ur(input bit sel);
        return sel ? ur2 : ur1;
    endfunction

    function automatic logic [1:0] tog(input logic [1:0] l);
        return (l == J) ? K : J;
    endfunction

    // Reference encoder for the default-parameter instance: bit stream
    // with stuffing, NRZI from J, then EOP.
    task automatic model_push(input logic [7:0] b0, input logic [7:0] b1,
                              input int nb, input bit under);
        logic [1:0] lvl;
        logic [7:0] byt;
        int         ones;
        lvl = J;
        for (int i = 0; i < 8; i++) begin
            if (i != 7) lvl = tog(lvl);
            exp_q.push_back(lvl);
        end
        ones = 1;
        for (int k = 0; k < nb; k++) begin
            byt = (k == 0) ? b0 : b1;
            for (int b = 0; b < 8; b++) begin
                if (ones == 6) begin
                    lvl = tog(lvl);
                    exp_q.push_back(lvl);
                    ones = 0;
                end
                if (byt[b]) begin
                    ones++;
                end else begin
                    lvl  = tog(lvl);
                    ones = 0;
                end
                exp_q.push_back(lvl);
            end
        end
        if (!under && ones == 6) exp_q.push_back(tog(lvl));
        for (int i = 0; i < 2; i++) exp_q.push_back(SE0);
        exp_q.push_back(J);
    endtask

    // Drives one packet, pops the scoreboard on every slot shown while
    // tx_oe is high, and checks that the line holds between strobes.
    task automatic run_pkt(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                           input int nb, input int period, input bit under,
                           output int slots, output int rdyc, output int urc);
        int         idx;
        int         cyc;
        bit         started;
        bit         done;
        bit         hs_now;
        bit         be;
        logic [1:0] prev;
        logic [1:0] e;
        idx = 0; cyc = 0; slots = 0; rdyc = 0; urc = 0;
        started = 0; done = 0;
        prev = get_ls(sel);
        while (!done && cyc < 3000) begin
            @(negedge clk);
            be = ((cyc % period) == 0);
            drive(sel, be, (idx < nb), (idx == 0) ? b0 : b1, (idx == nb - 1) && !under);
            #1;
            hs_now = (idx < nb) && get_rdy(sel);
            if (get_rdy(sel)) rdyc++;
            @(posedge clk);
            #1;
            if (hs_now) idx++;
            if (get_busy(sel)) started = 1;
            if (get_ur(sel)) urc++;
            if (be) begin
                if (get_oe(sel)) begin
                    slots++;
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 32'(slots), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("slot", 32'(get_ls(sel)), 32'(e));
                    end
                end
                prev = get_ls(sel);
            end else begin
                chk("hold", 32'(get_ls(sel)), 32'(prev));
            end
            done = started && !get_busy(sel);
            cyc++;
        end
        if (!done) chk("timeout", 32'(0), 32'(1));
        drive(sel, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("idle_j", 32'(get_ls(sel)), 32'(J));
        chk("sb_left", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    initial begin
        int slots;
        int rdyc;
        int urc;

        tbl[0] = '{8'h00, 8'h00, 1, 1, 1'b0, 19, 1, 0};
        tbl[1] = '{8'hFF, 8'h00, 1, 1, 1'b0, 20, 1, 0};
        tbl[2] = '{8'h3C, 8'hA5, 2, 1, 1'b0, 27, 2, 0};
        tbl[3] = '{8'h3C, 8'hA5, 2, 4, 1'b0, 27, 2, 0};
        tbl[4] = '{8'h12, 8'h00, 1, 1, 1'b1, 19, 2, 1};
        tbl[5] = '{8'hFF, 8'hFF, 2, 2, 1'b0, 29, 2, 0};
        tbl[6] = '{8'hFC, 8'h00, 1, 1, 1'b0, 20, 1, 0};
        tbl[7] = '{8'hFC, 8'h00, 1, 1, 1'b1, 19, 2, 1};
        tbl[8] = '{8'h12, 8'h00, 1, 3, 1'b1, 19, 2, 1};

        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 8'hAA, 1'b1);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("rst_ls", 32'(ls1), 32'(J));
        chk("rst_oe", 32'(oe1), 32'(0));
        chk("rst_busy", 32'(busy1), 32'(0));
        chk("rst_ur", 32'(ur1), 32'(0));
        chk("rst_rdy", 32'(rdy1), 32'(0));
        chk("rst_ls_b", 32'(ls2), 32'(J));
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            model_push(tbl[i].b0, tbl[i].b1, tbl[i].nb, tbl[i].under);
            run_pkt(0, tbl[i].b0, tbl[i].b1, tbl[i].nb, tbl[i].period, tbl[i].under,
                    slots, rdyc, urc);
            chk($sformatf("slots_v%0d", i), 32'(slots), 32'(tbl[i].exp_slots));
            chk($sformatf("rdy_v%0d", i), 32'(rdyc), 32'(tbl[i].exp_rdy));
            chk($sformatf("ur_v%0d", i), 32'(urc), 32'(tbl[i].exp_ur));
            repeat (2) @(negedge clk);
        end

        // reset in the middle of the data field
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'h55, 1'b1);
        repeat (12) @(posedge clk);
        #2;
        chk("oe_before_rst", 32'(oe1), 32'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_ls", 32'(ls1), 32'(J));
        chk("mid_rst_oe", 32'(oe1), 32'(0));
        chk("mid_rst_busy", 32'(busy1), 32'(0));
        chk("mid_rst_rdy", 32'(rdy1), 32'(0));
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_push(8'h00, 8'h00, 1, 1'b0);
        run_pkt(0, 8'h00, 8'h00, 1, 1, 1'b0, slots, rdyc, urc);
        chk("post_rst_slots", 32'(slots), 32'(19));

        // long HS SYNC, single SE0 in EOP, byte 0x80
        for (int i = 0; i < 31; i++) exp_q.push_back((i % 2 == 0) ? K : J);
        exp_q.push_back(K);
        for (int i = 0; i < 7; i++) exp_q.push_back((i % 2 == 0) ? J : K);
        exp_q.push_back(J);
        exp_q.push_back(SE0);
        exp_q.push_back(J);
        run_pkt(1, 8'h80, 8'h00, 1, 1, 1'b0, slots, rdyc, urc);
        chk("hs_slots", 32'(slots), 32'(42));
        chk("hs_rdy", 32'(rdyc), 32'(1));
        chk("hs_ur", 32'(urc), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
